// File: rtl/noise_gate.sv
// Noise gate: peak envelope follower driving an attack/hold/release gain ramp.
// One sample per clk_48 edge; gateOut is registered with one cycle of latency.
module noise_gate #(
    parameter int HOLD_SAMPLES = 2400,
    parameter int ATTACK_STEP  = 1024,
    parameter int RELEASE_STEP = 64,
    parameter int ENV_SHIFT    = 8
) (
    input  logic               clk_48,
    input  logic               reset,
    input  logic [2:0]         gate_sel,
    input  logic signed [15:0] gateIn,
    output logic signed [15:0] gateOut,
    output logic               gate_open
);
    localparam logic [15:0] UNITY = 16'h8000;
    localparam int          HCW   = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    typedef enum logic [2:0] {
        S_CLOSED  = 3'd0,
        S_ATTACK  = 3'd1,
        S_OPEN    = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [15:0]        r_gain, w_gain_nxt;
    logic [HCW-1:0]     r_hold, w_hold_nxt;
    logic [15:0]        r_env;

    logic [15:0]        w_abs;
    logic [15:0]        w_thr;
    logic [15:0]        w_close;
    logic               w_bypass;
    logic               w_env_ge;
    logic               w_env_lt_close;
    logic [16:0]        w_gain_sum;
    logic [15:0]        w_gain_up;
    logic [15:0]        w_gain_dn;
    logic signed [32:0] w_prod;
    logic signed [15:0] w_scaled;

    // Magnitude of the input; -32768 saturates to 32767 so it fits 15 bits.
    always_comb begin
        w_abs = gateIn;
        if (gateIn == 16'sh8000)
            w_abs = 16'h7FFF;
        else if (gateIn[15])
            w_abs = 16'(-gateIn);
    end

    // Threshold decode; any unlisted select value means bypass.
    always_comb begin
        w_bypass = 1'b0;
        w_thr    = 16'd0;
        case (gate_sel)
            3'd1:    w_thr = 16'd64;
            3'd2:    w_thr = 16'd256;
            3'd3:    w_thr = 16'd1024;
            3'd4:    w_thr = 16'd4096;
            default: w_bypass = 1'b1;
        endcase
    end

    // Hysteresis: open at T, close at T/2, both against the pre-edge envelope.
    assign w_close        = w_thr >> 1;
    assign w_env_ge       = (r_env >= w_thr);
    assign w_env_lt_close = (r_env < w_close);

    // Gain ramps clamp at unity / zero.
    assign w_gain_sum = {1'b0, r_gain} + 17'(ATTACK_STEP);
    assign w_gain_up  = (w_gain_sum >= {1'b0, UNITY}) ? UNITY : w_gain_sum[15:0];
    assign w_gain_dn  = (r_gain > 16'(RELEASE_STEP)) ? (r_gain - 16'(RELEASE_STEP)) : 16'd0;

    // Q15 scaling with the pre-edge gain; unity gain reproduces the input exactly.
    assign w_prod   = 33'(gateIn) * 33'($signed({1'b0, r_gain}));
    assign w_scaled = 16'(w_prod >>> 15);

    assign gate_open = (r_state == S_ATTACK) || (r_state == S_OPEN) || (r_state == S_HOLD);

    // Envelope: instant attack, exponential decay. Once the input goes quiet the
    // decay term reaches zero, so env settles just below 2**ENV_SHIFT.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset)
            r_env <= '0;
        else if (w_abs > r_env)
            r_env <= w_abs;
        else
            r_env <= r_env - (r_env >> ENV_SHIFT);
    end

    // Gate state, gain and hold counter registers.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            r_state <= S_CLOSED;
            r_gain  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state and gain ramp; bypass parks the gate fully open.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_hold_nxt  = r_hold;
        if (w_bypass) begin
            w_state_nxt = S_OPEN;
            w_gain_nxt  = UNITY;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                S_CLOSED: begin
                    w_gain_nxt = '0;
                    if (w_env_ge)
                        w_state_nxt = S_ATTACK;
                end
                S_ATTACK: begin
                    w_gain_nxt = w_gain_up;
                    if (w_gain_up == UNITY)
                        w_state_nxt = S_OPEN;
                end
                S_OPEN: begin
                    w_gain_nxt = UNITY;
                    if (w_env_lt_close) begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = HCW'(HOLD_SAMPLES - 1);
                    end
                end
                S_HOLD: begin
                    w_gain_nxt = UNITY;
                    if (w_env_ge)
                        w_state_nxt = S_OPEN;
                    else if (r_hold == '0)
                        w_state_nxt = S_RELEASE;
                    else
                        w_hold_nxt = r_hold - HCW'(1);
                end
                S_RELEASE: begin
                    // Retrigger keeps the current gain so the ramp back up is continuous.
                    if (w_env_ge)
                        w_state_nxt = S_ATTACK;
                    else begin
                        w_gain_nxt = w_gain_dn;
                        if (w_gain_dn == 16'd0)
                            w_state_nxt = S_CLOSED;
                    end
                end
                default: begin
                    w_state_nxt = S_CLOSED;
                    w_gain_nxt  = '0;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // Output register: straight delay in bypass, scaled sample otherwise.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset)
            gateOut <= '0;
        else if (w_bypass)
            gateOut <= gateIn;
        else
            gateOut <= w_scaled;
    end

endmodule

// File: tb/tb_noise_gate.sv
// Bench for noise_gate: directed scenarios plus a randomized run, all checked
// against a sample-level reference model of the gate.
module tb_noise_gate;
    localparam int HOLD = 16;
    localparam int ATK  = 1024;
    localparam int REL  = 64;
    localparam int ESH  = 4;

    localparam int P_CLOSED  = 0;
    localparam int P_ATTACK  = 1;
    localparam int P_OPEN    = 2;
    localparam int P_HOLD    = 3;
    localparam int P_RELEASE = 4;

    logic               clk_48 = 1'b0;
    logic               reset;
    logic [2:0]         gate_sel;
    logic signed [15:0] gateIn;
    logic signed [15:0] gateOut;
    logic               gate_open;

    int n_checks = 0;
    int n_errors = 0;

    int m_env, m_gain, m_hold, m_phase, m_out, prev_in;

    noise_gate #(
        .HOLD_SAMPLES(HOLD),
        .ATTACK_STEP (ATK),
        .RELEASE_STEP(REL),
        .ENV_SHIFT   (ESH)
    ) dut (
        .clk_48   (clk_48),
        .reset    (reset),
        .gate_sel (gate_sel),
        .gateIn   (gateIn),
        .gateOut  (gateOut),
        .gate_open(gate_open)
    );

    always #5 clk_48 = ~clk_48;

    function automatic int thr_of(input int sel);
        case (sel)
            1:       return 64;
            2:       return 256;
            3:       return 1024;
            4:       return 4096;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_open();
        return (m_phase == P_ATTACK) || (m_phase == P_OPEN) || (m_phase == P_HOLD);
    endfunction

    task automatic model_reset();
        m_env = 0; m_gain = 0; m_hold = 0; m_phase = P_CLOSED; m_out = 0; prev_in = 0;
    endtask

    // One sample of the gate, straight from the behavioural rules.
    task automatic model_step(input int sel, input int x);
        int thr, a, e;
        thr = thr_of(sel);
        e   = m_env;
        a   = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        m_out = (thr == 0) ? x : ((x * m_gain) >>> 15);
        m_env = (a > e) ? a : e - (e >> ESH);
        if (thr == 0) begin
            m_phase = P_OPEN; m_gain = 32768; m_hold = 0;
        end else begin
            case (m_phase)
                P_CLOSED: begin
                    m_gain = 0;
                    if (e >= thr) m_phase = P_ATTACK;
                end
                P_ATTACK: begin
                    m_gain = (m_gain + ATK > 32768) ? 32768 : m_gain + ATK;
                    if (m_gain == 32768) m_phase = P_OPEN;
                end
                P_OPEN: begin
                    if (e < thr / 2) begin m_phase = P_HOLD; m_hold = HOLD - 1; end
                end
                P_HOLD: begin
                    if (e >= thr) m_phase = P_OPEN;
                    else if (m_hold == 0) m_phase = P_RELEASE;
                    else m_hold = m_hold - 1;
                end
                P_RELEASE: begin
                    if (e >= thr) m_phase = P_ATTACK;
                    else begin
                        m_gain = (m_gain - REL < 0) ? 0 : m_gain - REL;
                        if (m_gain == 0) m_phase = P_CLOSED;
                    end
                end
                default: m_phase = P_CLOSED;
            endcase
        end
    endtask

    // Drive one sample, let the edge happen, advance the model, settle 1 time unit.
    task automatic tick(input logic [2:0] sel, input logic signed [15:0] x);
        gate_sel = sel;
        gateIn   = x;
        @(posedge clk_48);
        model_step(int'(sel), int'(x));
        prev_in = int'(x);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; gate_sel = 3'd0; gateIn = 16'sd1000;
        #3;
        n_checks++;
        if (gateOut !== 16'sd0 || gate_open !== 1'b0) begin
            n_errors++; $display("FAIL reset_state got out=%0d open=%b exp out=0 open=0", gateOut, gate_open);
        end
        reset = 1'b0;
        model_reset();
        tick(3'd0, 16'sd1000);
        n_checks++;
        if (gateOut !== 16'sd1000) begin
            n_errors++; $display("FAIL bypass_first got %0d exp 1000", gateOut);
        end
        n_checks++;
        if (gate_open !== 1'b1) begin
            n_errors++; $display("FAIL bypass_open got %b exp 1", gate_open);
        end
    endtask

    task automatic test_bypass();
        logic [2:0] sels [4] = '{3'd0, 3'd5, 3'd6, 3'd7};
        int x;
        for (int i = 0; i < 24; i++) begin
            x = (i == 0) ? -32768 : (i == 1) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
            tick(sels[$urandom_range(0, 3)], 16'(x));
            n_checks++;
            if (gateOut !== 16'(x) || gate_open !== 1'b1) begin
                n_errors++; $display("FAIL bypass_delay i=%0d got out=%0d open=%b exp out=%0d open=1", i, gateOut, gate_open, x);
            end
        end
    endtask

    task automatic test_below_threshold();
        apply_reset();
        for (int i = 1; i <= 100; i++) begin
            tick(3'd2, 16'sd100);
            n_checks++;
            if (gateOut !== 16'sd0 || gate_open !== 1'b0) begin
                n_errors++; $display("FAIL below_thr edge %0d got out=%0d open=%b exp out=0 open=0", i, gateOut, gate_open);
            end
        end
    endtask

    task automatic test_attack();
        apply_reset();
        for (int e = 1; e <= 40; e++) begin
            tick(3'd2, 16'sd1000);
            n_checks++;
            if (gateOut !== 16'(m_out) || gate_open !== model_open()) begin
                n_errors++; $display("FAIL attack_model edge %0d got out=%0d open=%b exp out=%0d open=%b", e, gateOut, gate_open, m_out, model_open());
            end
            if (e == 1) begin
                n_checks++;
                if (gate_open !== 1'b0) begin n_errors++; $display("FAIL attack_e1 got open=%b exp 0", gate_open); end
            end
            if (e == 2) begin
                n_checks++;
                if (gate_open !== 1'b1) begin n_errors++; $display("FAIL attack_e2 got open=%b exp 1", gate_open); end
            end
            if (e == 4) begin
                n_checks++;
                if (gateOut !== 16'sd31) begin n_errors++; $display("FAIL attack_e4 got %0d exp 31", gateOut); end
            end
            if (e == 34) begin
                n_checks++;
                if (gateOut === 16'sd1000) begin n_errors++; $display("FAIL attack_e34 got %0d exp below 1000", gateOut); end
            end
            if (e >= 35) begin
                n_checks++;
                if (gateOut !== 16'sd1000) begin n_errors++; $display("FAIL attack_open edge %0d got %0d exp 1000", e, gateOut); end
            end
        end
    endtask

    // Continues from the open gate left by test_attack.
    task automatic test_hold_release();
        int e_env, e_drop;
        e_env = -1; e_drop = -1;
        for (int e = 1; e <= 620; e++) begin
            tick(3'd2, 16'sd100);
            if (e_env < 0 && m_env < 128) e_env = e;
            if (e_drop < 0 && gate_open === 1'b0) begin
                e_drop = e;
                n_checks++;
                if (gateOut !== 16'sd100) begin n_errors++; $display("FAIL release_entry_out got %0d exp 100", gateOut); end
            end
            n_checks++;
            if (gateOut !== 16'(m_out) || gate_open !== model_open()) begin
                n_errors++; $display("FAIL release_model edge %0d got out=%0d open=%b exp out=%0d open=%b", e, gateOut, gate_open, m_out, model_open());
            end
        end
        n_checks++;
        if (e_env < 0 || e_drop != e_env + HOLD + 1) begin
            n_errors++; $display("FAIL hold_len got drop=%0d exp %0d", e_drop, e_env + HOLD + 1);
        end
        n_checks++;
        if (gateOut !== 16'sd0 || gate_open !== 1'b0) begin
            n_errors++; $display("FAIL closed_end got out=%0d open=%b exp out=0 open=0", gateOut, gate_open);
        end
    endtask

    task automatic test_retrigger();
        int n, last;
        apply_reset();
        for (int i = 0; i < 40; i++) tick(3'd2, 16'sd1000);
        n = 0;
        do begin
            tick(3'd2, 16'sd100);
            n++;
        end while (gate_open !== 1'b0 && n < 300);
        n_checks++;
        if (gate_open !== 1'b0) begin
            n_errors++; $display("FAIL retrig_release_timeout got open=%b exp 0", gate_open);
            return;
        end
        for (int i = 0; i < 255; i++) tick(3'd2, 16'sd100);
        tick(3'd2, 16'sd1000);
        n_checks++;
        if (gate_open !== 1'b0) begin n_errors++; $display("FAIL retrig_pre got open=%b exp 0", gate_open); end
        last = 0;
        for (int k = 0; k <= 20; k++) begin
            tick(3'd2, 16'sd1000);
            n_checks++;
            if (gateOut !== 16'(m_out) || gate_open !== 1'b1) begin
                n_errors++; $display("FAIL retrig_model k=%0d got out=%0d open=%b exp out=%0d open=1", k, gateOut, gate_open, m_out);
            end
            if (k == 0 || k == 1) begin
                n_checks++;
                if (gateOut !== 16'sd500) begin n_errors++; $display("FAIL retrig_start k=%0d got %0d exp 500", k, gateOut); end
            end
            if (k == 16) begin
                n_checks++;
                if (gateOut !== 16'sd968) begin n_errors++; $display("FAIL retrig_k16 got %0d exp 968", gateOut); end
            end
            if (k >= 17) begin
                n_checks++;
                if (gateOut !== 16'sd1000) begin n_errors++; $display("FAIL retrig_open k=%0d got %0d exp 1000", k, gateOut); end
            end
            if (k >= 1) begin
                n_checks++;
                if (int'(gateOut) < last || int'(gateOut) - last > 32) begin
                    n_errors++; $display("FAIL retrig_step k=%0d got %0d after %0d exp step 0..32", k, gateOut, last);
                end
            end
            last = int'(gateOut);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 10; i++) tick(3'd2, 16'sd1000);
        n_checks++;
        if (gateOut !== 16'sd218 || gate_open !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset got out=%0d open=%b exp out=218 open=1", gateOut, gate_open);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (gateOut !== 16'sd0 || gate_open !== 1'b0) begin
            n_errors++; $display("FAIL async_reset got out=%0d open=%b exp out=0 open=0", gateOut, gate_open);
        end
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int sel, mode, mag, x, left;
        apply_reset();
        sel = 2; mode = 1; left = 0;
        for (int i = 0; i < 700; i++) begin
            if (left == 0) begin
                sel  = $urandom_range(0, 7);
                mode = $urandom_range(0, 2);
                left = $urandom_range(20, 90);
            end
            left--;
            case (mode)
                0:       mag = $urandom_range(0, 60);
                1:       mag = $urandom_range(0, 1500);
                default: mag = $urandom_range(0, 32767);
            endcase
            x = ($urandom_range(0, 1) == 1) ? -mag : mag;
            if (mode == 2 && $urandom_range(0, 15) == 0) x = -32768;
            tick(3'(sel), 16'(x));
            n_checks++;
            if (gateOut !== 16'(m_out) || gate_open !== model_open()) begin
                n_errors++; $display("FAIL random i=%0d sel=%0d in=%0d got out=%0d open=%b exp out=%0d open=%b", i, sel, x, gateOut, gate_open, m_out, model_open());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_below_threshold();
        test_attack();
        test_hold_release();
        test_retrigger();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
